conv_encoder_tx: RTL and testbench
==================================

// Module: conv_encoder_tx
// PURPOSE
//   Transmit-side rate-1/2 convolutional encoder paired with the Viterbi decoder.
//   Accepts info bits on a valid/ready stream and emits one 2-bit coded symbol per bit.
//   Appends K-1 zero tail bits per frame so the trellis ends in state 0.
//   Each frame is FRAME_LEN+K-1 = 64 symbols, the decoder's sequence length.
// PARAMETERS
//   K          3     constraint length; state register is K-1 bits
//   G0         3'o7  generator for out_sym[1]; MSB taps current input
//   G1         3'o5  generator for out_sym[0]; MSB taps current input
//   FRAME_LEN  62    info bits per frame; FRAME_LEN+K-1 must equal decoder seq_num
//   CNT_W      6     bit counter width; must hold FRAME_LEN-1 (clog2(FRAME_LEN))
// PORTS
//   CLK        in   1  clock, rising edge
//   RST        in   1  reset, asynchronous, active-low
//   in_valid   in   1  in_bit is valid
//   in_bit     in   1  info bit
//   in_ready   out  1  encoder accepts in_bit this cycle
//   out_valid  out  1  out_sym/out_last valid (feeds decoder Data_Valid)
//   out_sym    out  2  coded symbol {G0 parity, G1 parity}
//   out_last   out  1  marks the final (tail) symbol of a frame
//   out_ready  in   1  downstream consumes symbol this cycle
//   busy       out  1  high when state != IDLE
//   frame_done out  1  1-cycle pulse when the final tail symbol is loaded
// BEHAVIOUR
//   Reset (RST=0, async):
//     state=IDLE, sr=0, bit_cnt=0, tail_cnt=0.
//     out_valid=0, out_sym=0, out_last=0, frame_done=0.
//   Register vector: v = {u, sr[K-2:0]}, where sr[K-2] is the newest past bit.
//     out_sym[1] = ^(v & G0); out_sym[0] = ^(v & G1).
//     Next sr = v[K-1:1]. Parity is pure XOR, no arithmetic widening.
//   Slot free: slot = !out_valid || out_ready (one-deep output register).
//   Load: when a symbol is loaded, out_sym, out_last and out_valid=1 register next cycle.
//     out_valid clears when out_ready=1 and nothing loads.
//     Zero-bubble throughput: 1 symbol/cycle when out_ready stays 1.
//   Stall: out_ready=0 with out_valid=1 holds out_sym and out_last stable; no new load.
//   in_ready = (state==IDLE || state==ENCODE) && slot. Combinational; no in_valid dependency.
//   Input accept: in_valid && in_ready loads a symbol with u=in_bit and increments bit_cnt.
//   FSM:
//     IDLE:   on accept: sr advance, bit_cnt=1.
//             If FRAME_LEN==1 go TAIL, else go ENCODE.
//     ENCODE: on accept with bit_cnt==FRAME_LEN-1: go TAIL, bit_cnt=0.
//             Otherwise stay. in_valid=0 inserts bubbles; state is held.
//     TAIL:   in_ready=0 and in_valid is ignored.
//             Each cycle with slot=1: load a symbol with u=0 and increment tail_cnt.
//             On load with tail_cnt==K-2: out_last=1, frame_done=1, sr=0 (already 0).
//             Then tail_cnt=0 and go IDLE.
//     Other encodings go to IDLE.
//   Back-to-back frames: IDLE accepts the first bit of the next frame the cycle after
//     the final tail load, if slot=1.
//   Reset mid-frame: everything clears immediately. A partially sent frame is abandoned;
//     the decoder is reset together.
//   Latency: in_bit accepted at cycle n -> out_valid with its symbol at n+1.
// STRUCTURE
//   Package viterbi_pkg:
//     localparams K, G0, G1, SEQ_NUM=64.
//     State encoding IDLE/ENCODE/TAIL (2 bits).
//     The decoder FSM also uses this package so both ends share K and the generators.
//   Sub-module conv_sym_gen (combinational): v[K-1:0] -> sym[1:0].
//     Reused by the decoder's branch-metric expected-symbol table.
//   Top: FSM, bit_cnt, tail_cnt, sr, output register.
// TESTING
//   T1 Golden: FRAME_LEN=4, bits 1,0,1,1, out_ready=1
//      -> symbols 11,10,00,01,01,11; out_last on 6th; one frame_done; sr=0 after.
//   T2 Full frame: 62 random bits
//      -> 64 symbols; out_last only on #64; matches reference model.
//      Decoder in loop recovers all 62 bits.
//   T3 Backpressure: hold out_ready=0 for 5 cycles mid-frame
//      -> in_ready=0; out_sym stable; no symbol lost or duplicated.
//      Same for a stall during TAIL.
//   T4 Bubbles and tail input: in_valid toggles 1,0,1,...; in_valid=1 during TAIL
//      -> tail bits ignored, symbol count stays 64, state held across bubbles.
//   T5 Back-to-back: two frames with in_valid and out_ready held 1
//      -> exactly 2 idle input cycles (K-1 tail) between frames; 128 symbols; two frame_done pulses.
//   T6 Reset mid-ENCODE (after bit 30): RST low 1 cycle
//      -> all outputs 0 asynchronously; next frame encodes from state 0 and matches golden.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the convolutional encoder and the Viterbi decoder.
// Both ends import this package so K and the generators cannot drift apart.
package viterbi_pkg;

    localparam int unsigned K       = 3;
    localparam logic [K-1:0] G0     = 3'o7;
    localparam logic [K-1:0] G1     = 3'o5;
    localparam int unsigned SEQ_NUM = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        TAIL   = 2'd2
    } enc_state_e;

endpackage

// File: rtl/conv_encoder_tx_if.sv
// Bit-in / symbol-out stream bundle of the convolutional encoder.
// master is the encoder's view and slave is the view of the surrounding logic.
interface conv_encoder_tx_if;

    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_sym;
    logic       out_last;
    logic       out_ready;

    modport master (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_sym, out_last
    );

    modport slave (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_sym, out_last
    );

endinterface

// File: rtl/conv_sym_gen.sv
// Rate-1/2 coded symbol for one register vector {u, past bits}.
// Shared with the decoder's expected-symbol table.
module conv_sym_gen
    import viterbi_pkg::*;
(
    input  logic [K-1:0] v,
    output logic [1:0]   sym
);

    assign sym = {^(v & G0), ^(v & G1)};

endmodule

// File: rtl/conv_encoder_tx.sv
// Framed rate-1/2 convolutional encoder: FRAME_LEN info bits then K-1 zero tail
// bits per frame, one symbol per cycle through a one-deep output register.
module conv_encoder_tx
    import viterbi_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 62,
    parameter int unsigned CNT_W     = 6
) (
    input  logic                CLK,
    input  logic                RST,
    conv_encoder_tx_if.master   bus,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned TAIL_W = K - 1;

    enc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [TAIL_W-1:0] tail_cnt_q, tail_cnt_d;
    logic [K-2:0]      sr_q, sr_d;

    logic              out_valid_q;
    logic [1:0]        out_sym_q;
    logic              out_last_q;
    logic              frame_done_q;

    logic              slot;
    logic              load;
    logic              load_last;
    logic              u;
    logic [K-1:0]      v;
    logic [1:0]        sym;

    // The output register can take a new symbol when empty or being drained.
    assign slot         = !out_valid_q || bus.out_ready;
    assign bus.in_ready = ((state_q == IDLE) || (state_q == ENCODE)) && slot;

    assign u = (state_q == TAIL) ? 1'b0 : bus.in_bit;
    assign v = {u, sr_q};

    conv_sym_gen u_sym_gen (
        .v   (v),
        .sym (sym)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tail_cnt_d = tail_cnt_q;
        sr_d       = sr_q;
        load       = 1'b0;
        load_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    load = 1'b1;
                    sr_d = v[K-1:1];
                    if (FRAME_LEN == 1) begin
                        state_d   = TAIL;
                        bit_cnt_d = '0;
                    end else begin
                        state_d   = ENCODE;
                        bit_cnt_d = CNT_W'(1);
                    end
                end
            end
            ENCODE: begin
                if (bus.in_valid && bus.in_ready) begin
                    load = 1'b1;
                    sr_d = v[K-1:1];
                    if (bit_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        state_d   = TAIL;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            TAIL: begin
                // Zero inputs flush the register, so sr is back at 0 after the last one.
                if (slot) begin
                    load = 1'b1;
                    sr_d = v[K-1:1];
                    if (tail_cnt_q == TAIL_W'(K - 2)) begin
                        load_last  = 1'b1;
                        tail_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        tail_cnt_d = tail_cnt_q + TAIL_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            tail_cnt_q   <= '0;
            sr_q         <= '0;
            out_valid_q  <= 1'b0;
            out_sym_q    <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            tail_cnt_q   <= tail_cnt_d;
            sr_q         <= sr_d;
            frame_done_q <= load_last;
            if (load) begin
                out_valid_q <= 1'b1;
                out_sym_q   <= sym;
                out_last_q  <= load_last;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sym   = out_sym_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q != IDLE);
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Randomized bench for conv_encoder_tx against a generator-polynomial reference model,
// plus a short-frame golden vector on a second instance.
module tb_conv_encoder_tx;

    localparam int FrameLen = 62;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    conv_encoder_tx_if enc_if ();
    conv_encoder_tx_if enc4_if ();
    logic busy, frame_done, busy4, frame_done4;

    conv_encoder_tx #(.FRAME_LEN(FrameLen), .CNT_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (enc_if),
        .busy       (busy),
        .frame_done (frame_done)
    );

    conv_encoder_tx #(.FRAME_LEN(4), .CNT_W(2)) dut4 (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (enc4_if),
        .busy       (busy4),
        .frame_done (frame_done4)
    );

    int         n_checks   = 0;
    int         n_errors   = 0;
    int         n_done     = 0;
    int         frames_exp = 0;
    int         n_sym      = 0;
    logic [2:0] exp_q[$];
    int         frame_bits[$];
    logic       stall_prev = 1'b0;
    logic [2:0] stall_val  = '0;
    logic       tail_chk   = 1'b0;

    logic [1:0] gold [0:5] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    logic [3:0] bits4      = 4'b1101;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Info bit i of the current frame; zero before the frame and in the tail.
    function automatic int bit_at(input int i);
        return (i >= 0 && i < frame_bits.size()) ? frame_bits[i] : 0;
    endfunction

    // g0 = 1 + D + D^2, g1 = 1 + D^2
    function automatic logic [1:0] ref_sym(input int i);
        int a, b, c;
        a = bit_at(i);
        b = bit_at(i - 1);
        c = bit_at(i - 2);
        return {1'((a + b + c) % 2), 1'((a + c) % 2)};
    endfunction

    task automatic step(input logic v, input logic b, input logic r, input logic gate,
                        output logic acc);
        logic [2:0] e;
        @(negedge CLK);
        enc_if.in_valid  = gate ? (v && busy) : v;
        enc_if.in_bit    = b;
        enc_if.out_ready = r;
        #1;
        if (frame_done) n_done++;
        if (tail_chk) begin
            check_eq("tail_in_ready", enc_if.in_ready, 0);
            tail_chk = 1'b0;
        end
        if (stall_prev) begin
            check_eq("stall_hold", {enc_if.out_last, enc_if.out_sym}, stall_val);
            check_eq("stall_valid", enc_if.out_valid, 1);
        end
        if (enc_if.out_valid && !r) check_eq("stall_in_ready", enc_if.in_ready, 0);
        if (enc_if.out_valid && r) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_sym", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_eq("sym", {enc_if.out_last, enc_if.out_sym}, e);
                n_sym++;
            end
        end
        stall_prev = enc_if.out_valid && !r;
        stall_val  = {enc_if.out_last, enc_if.out_sym};
        acc = enc_if.in_valid && enc_if.in_ready;
        if (acc) begin
            frame_bits.push_back(int'(b));
            exp_q.push_back({1'b0, ref_sym(frame_bits.size() - 1)});
            if (frame_bits.size() == FrameLen) begin
                exp_q.push_back({1'b0, ref_sym(FrameLen)});
                exp_q.push_back({1'b1, ref_sym(FrameLen + 1)});
                frames_exp++;
                tail_chk = 1'b1;
                frame_bits.delete();
            end
        end
    endtask

    task automatic send_bits(input int n, input int vmode, input int rmode);
        int   acc = 0;
        logic a, v, r;
        for (int cyc = 0; cyc < 4000 && acc < n; cyc++) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            case (rmode)
                0:       r = 1'b1;
                1:       r = !(cyc >= 20 && cyc < 25);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            step(v, 1'($urandom_range(0, 1)), r, 1'b0, a);
            if (a) acc++;
        end
        check_eq("bits_accepted", acc, n);
    endtask

    // Flush tail and pending symbols; in_valid may stay high while the encoder is busy.
    task automatic drain(input int stall_cycles, input logic v_tail);
        logic a;
        int   i = 0;
        while (exp_q.size() != 0 && i < 400) begin
            step(v_tail, 1'($urandom_range(0, 1)), (i >= stall_cycles), 1'b1, a);
            i++;
        end
        check_eq("drain_empty", exp_q.size(), 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, a);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_valid", enc_if.out_valid, 0);
        check_eq("frame_done_cnt", n_done, frames_exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int   k, i, done4, base_sym, base_done, first, gap, acc2, last_cyc;
        logic a;

        enc_if.in_valid   = 1'b0;
        enc_if.in_bit     = 1'b0;
        enc_if.out_ready  = 1'b0;
        enc4_if.in_valid  = 1'b0;
        enc4_if.in_bit    = 1'b0;
        enc4_if.out_ready = 1'b1;

        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_out_valid", enc_if.out_valid, 0);
        check_eq("rst_out_sym", enc_if.out_sym, 0);
        check_eq("rst_out_last", enc_if.out_last, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_busy", busy, 0);
        @(negedge CLK);
        RST = 1'b1;

        // Golden short frame, sent twice back to back to show the register returns to 0.
        done4 = 0;
        for (int rep = 0; rep < 2; rep++) begin
            k = 0;
            i = 0;
            for (int c = 0; c < 20 && k < 6; c++) begin
                @(negedge CLK);
                if (frame_done4) done4++;
                if (enc4_if.out_valid) begin
                    check_eq("t1_sym", enc4_if.out_sym, gold[k]);
                    check_eq("t1_last", enc4_if.out_last, (k == 5));
                    k++;
                end
                enc4_if.in_valid = (i < 4);
                enc4_if.in_bit   = (i < 4) ? bits4[i] : 1'b0;
                #1;
                if (enc4_if.in_valid && enc4_if.in_ready) i++;
            end
            check_eq("t1_count", k, 6);
            check_eq("t1_frame_done", done4, rep + 1);
        end
        enc4_if.in_valid = 1'b0;

        // Full frame, free-running
        send_bits(FrameLen, 0, 0);
        drain(0, 1'b0);
        // Backpressure mid-frame and during the tail
        send_bits(FrameLen, 0, 1);
        drain(5, 1'b0);
        // Input bubbles, in_valid held high through the tail
        send_bits(FrameLen, 1, 0);
        drain(0, 1'b1);
        // Random valid and ready
        send_bits(FrameLen, 2, 2);
        drain(3, 1'b1);

        // Back-to-back frames
        base_sym  = n_sym;
        base_done = n_done;
        first     = -1;
        gap       = 0;
        acc2      = 0;
        last_cyc  = -1;
        for (int c = 0; c < 600 && (n_sym - base_sym) < 128; c++) begin
            step((acc2 < 2 * FrameLen), 1'($urandom_range(0, 1)), 1'b1, 1'b0, a);
            if (a) begin
                if (first < 0) first = c;
                acc2++;
            end else if (first >= 0 && acc2 < 2 * FrameLen) begin
                gap++;
            end
            if ((n_sym - base_sym) == 128) last_cyc = c;
        end
        check_eq("b2b_symbols", n_sym - base_sym, 128);
        check_eq("b2b_gap", gap, 2);
        check_eq("b2b_span", last_cyc - first, 128);
        drain(0, 1'b0);
        check_eq("b2b_frame_done", n_done - base_done, 2);

        // Reset after 30 bits of a frame
        send_bits(30, 0, 0);
        @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check_eq("arst_out_valid", enc_if.out_valid, 0);
        check_eq("arst_out_sym", enc_if.out_sym, 0);
        check_eq("arst_out_last", enc_if.out_last, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_frame_done", frame_done, 0);
        enc_if.in_valid = 1'b0;
        exp_q.delete();
        frame_bits.delete();
        stall_prev = 1'b0;
        tail_chk   = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        send_bits(FrameLen, 0, 0);
        drain(0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
